// File: rtl/stable_matching_pkg.sv
// Shared types and helpers for the sequential Gale-Shapley matcher.
// Optional proposal budget: STABLE_MATCHING_SEQ_ITER_LIMIT_EN.
package stable_matching_pkg;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int S_DEF = 10;
    localparam int R_DEF = 10;
    localparam int LOGS  = clog2_min1(S_DEF);
    localparam int LOGR  = clog2_min1(R_DEF);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/sm_free_pick.sv
// Lowest-index picker over the eligible-proposer vector.
// Purely combinational; any_o flags a non-empty vector.
module sm_free_pick
    import stable_matching_pkg::*;
#(
    parameter int S = 10,
    parameter int W = clog2_min1(S)
) (
    input  logic [S-1:0] elig_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        idx_o = '0;
        for (int i = S - 1; i >= 0; i--) begin
            if (elig_i[i]) idx_o = W'(i);
        end
    end

    assign any_o = |elig_i;

endmodule

// File: rtl/stable_matching_seq.sv
// Sequential Gale-Shapley engine, one proposal per clock.
// Define STABLE_MATCHING_SEQ_ITER_LIMIT_EN to cap proposals at N.
module stable_matching_seq #(
    parameter int S  = 10,
    parameter int R  = 10,
    parameter int Ks = 10,
    parameter int Kr = 10,
    parameter int N  = S * S - S + 2,
    localparam int LOGS = stable_matching_pkg::clog2_min1(S),
    localparam int LOGR = stable_matching_pkg::clog2_min1(R),
    localparam int PW   = R * Kr * LOGS + S * Ks * LOGR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [PW-1:0]     p_input,
    output logic              busy_o,
    output logic              done_o,
    output logic [R*LOGS-1:0] match_o,
    output logic [R-1:0]      match_vld_o,
    output logic              timeout_o
);
    import stable_matching_pkg::*;

    localparam int PTRW = $clog2(Ks + 1);
    localparam int RKW  = $clog2(Kr + 1);
    localparam int RB   = R * Kr * LOGS;

    state_t              state_q;
    logic [PW-1:0]       pin_q;
    logic [PTRW-1:0]     ptr_q [S];
    logic [S-1:0]        free_q;
    logic [R*LOGS-1:0]   match_q;
    logic [R-1:0]        vld_q;
    logic                busy_q, done_q, timeout_q;

    logic [S-1:0]        elig;
    logic [LOGS-1:0]     s_idx;
    logic                s_any;
    logic [LOGR-1:0]     r_sel;
    logic                r_ok;
    int                  r_i;
    logic [LOGS-1:0]     cur;
    logic [RKW-1:0]      rk_new, rk_cur;
    logic                accept;
    logic                budget_hit;

    function automatic logic [LOGR-1:0] pref_a(
        input logic [PW-1:0] p, input int s, input int k);
        return p[RB + (s * Ks + k) * LOGR +: LOGR];
    endfunction

    function automatic logic [LOGS-1:0] pref_b(
        input logic [PW-1:0] p, input int r, input int k);
        return p[(r * Kr + k) * LOGS +: LOGS];
    endfunction

    always_comb begin
        elig = '0;
        for (int s = 0; s < S; s++) begin
            elig[s] = free_q[s] && (ptr_q[s] < PTRW'(Ks));
        end
    end

    sm_free_pick #(.S(S), .W(LOGS)) u_pick (
        .elig_i (elig),
        .idx_o  (s_idx),
        .any_o  (s_any)
    );

    // Both ranks come from the same receiver list; descending scan keeps
    // the first occurrence of a duplicated proposer.
    always_comb begin
        r_sel  = pref_a(pin_q, int'(s_idx), int'(ptr_q[s_idx]));
        r_ok   = int'(r_sel) < R;
        r_i    = r_ok ? int'(r_sel) : 0;
        cur    = match_q[r_i * LOGS +: LOGS];
        rk_new = RKW'(Kr);
        rk_cur = RKW'(Kr);
        for (int k = Kr - 1; k >= 0; k--) begin
            if (pref_b(pin_q, r_i, k) == s_idx) rk_new = RKW'(k);
            if (pref_b(pin_q, r_i, k) == cur)   rk_cur = RKW'(k);
        end
        accept = s_any && r_ok && (rk_new != RKW'(Kr)) &&
                 (!vld_q[r_i] || (rk_new < rk_cur));
    end

`ifdef STABLE_MATCHING_SEQ_ITER_LIMIT_EN
    localparam int CW = $clog2(N + 1);
    logic [CW-1:0] cnt_q;
    assign budget_hit = (cnt_q == CW'(N));
`else
    logic unused_n;
    assign unused_n   = |N;
    assign budget_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pin_q     <= '0;
            free_q    <= '1;
            match_q   <= '0;
            vld_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            for (int s = 0; s < S; s++) ptr_q[s] <= '0;
`ifdef STABLE_MATCHING_SEQ_ITER_LIMIT_EN
            cnt_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        pin_q   <= p_input;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    match_q   <= '0;
                    vld_q     <= '0;
                    free_q    <= '1;
                    timeout_q <= 1'b0;
                    for (int s = 0; s < S; s++) ptr_q[s] <= '0;
`ifdef STABLE_MATCHING_SEQ_ITER_LIMIT_EN
                    cnt_q     <= '0;
`endif
                    state_q   <= RUN;
                end
                RUN: begin
                    if (budget_hit || !s_any) begin
                        timeout_q <= budget_hit;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        ptr_q[s_idx] <= ptr_q[s_idx] + 1'b1;
`ifdef STABLE_MATCHING_SEQ_ITER_LIMIT_EN
                        cnt_q <= cnt_q + 1'b1;
`endif
                        if (accept) begin
                            match_q[r_i * LOGS +: LOGS] <= s_idx;
                            vld_q[r_i]    <= 1'b1;
                            free_q[s_idx] <= 1'b0;
                            if (vld_q[r_i]) free_q[cur] <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign match_o     = match_q;
    assign match_vld_o = vld_q;
    assign timeout_o   = timeout_q;

endmodule
